// File: rtl/sc1_bus_pkg.sv
// sc1_bus_pkg: shared state encoding and sizing for the SC1 blitter bus arbiter
package sc1_bus_pkg;
    localparam int ACCESS_CYCLES_DEF = 2;
    localparam int CNT_W = 4;
    typedef enum logic [2:0] {IDLE, HALT_REQ, GRANTED, ACCESS, ACK, RELEASE} state_e;
endpackage

// File: rtl/sc1_wait_timer.sv
// sc1_wait_timer: loadable down-counter that parks at zero and flags it
module sc1_wait_timer
    import sc1_bus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/sc1_bus_arbiter.sv
// sc1_bus_arbiter: 6809 HALT handshake plus timed blitter video-RAM accesses
module sc1_bus_arbiter
    import sc1_bus_pkg::*;
#(
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_sync,
    input  logic        cpu_bus_avail,
    output logic        cpu_halt,
    input  logic        halt,
    output logic        halt_ack,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] blt_address,
    input  logic [7:0]  blt_wdata,
    input  logic        en_upper,
    input  logic        en_lower,
    output logic        blt_ack,
    output logic [7:0]  blt_rdata,
    output logic        blt_owns_bus,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_oe,
    output logic        mem_we_upper,
    output logic        mem_we_lower
);
    state_e      state_q, state_d;
    logic        load, cnt_zero;
    logic        wr_q, wr_d, eu_q, eu_d, el_q, el_d;
    logic        cpu_halt_q, grant_q, ack_q, oe_q, weu_q, wel_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q, rdata_q;

    sc1_wait_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .val_i  (CNT_W'(ACCESS_CYCLES - 1)),
        .zero_o (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = halt ? HALT_REQ : IDLE;
            HALT_REQ: state_d = !halt ? RELEASE : (cpu_bus_avail && e_sync) ? GRANTED : HALT_REQ;
            GRANTED:  state_d = !halt ? RELEASE : (read || write) ? ACCESS : GRANTED;
            ACCESS:   state_d = cnt_zero ? ACK : ACCESS;
            ACK:      state_d = GRANTED;
            RELEASE:  state_d = cpu_bus_avail ? RELEASE : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // write wins over read when both are requested
    assign load = state_q == GRANTED && state_d == ACCESS;
    assign wr_d = load ? write : wr_q;
    assign eu_d = load ? en_upper : eu_q;
    assign el_d = load ? en_lower : el_q;

    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            eu_q       <= 1'b0;
            el_q       <= 1'b0;
            cpu_halt_q <= 1'b0;
            grant_q    <= 1'b0;
            ack_q      <= 1'b0;
            oe_q       <= 1'b0;
            weu_q      <= 1'b0;
            wel_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            eu_q       <= eu_d;
            el_q       <= el_d;
            cpu_halt_q <= state_d inside {HALT_REQ, GRANTED, ACCESS, ACK};
            grant_q    <= state_d inside {GRANTED, ACCESS, ACK};
            ack_q      <= state_d == ACK;
            oe_q       <= state_d == ACCESS && !wr_d;
            weu_q      <= state_d == ACCESS && wr_d && eu_d;
            wel_q      <= state_d == ACCESS && wr_d && el_d;
            addr_q     <= load ? blt_address : addr_q;
            wdata_q    <= (load && write) ? blt_wdata : wdata_q;
            rdata_q    <= (state_q == ACCESS && cnt_zero && !wr_q) ? mem_rdata : rdata_q;
        end
    end

    assign cpu_halt     = cpu_halt_q;
    assign halt_ack     = grant_q;
    assign blt_owns_bus = grant_q;
    assign blt_ack      = ack_q;
    assign blt_rdata    = rdata_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_oe       = oe_q;
    assign mem_we_upper = weu_q;
    assign mem_we_lower = wel_q;
endmodule

// File: tb/tb_sc1_bus_arbiter.sv
// tb_sc1_bus_arbiter: directed stimulus with a queue-based scoreboard on blt_ack
module tb_sc1_bus_arbiter;
    localparam int AC = 2;

    logic        clk = 1'b0, reset = 1'b1, e_sync = 1'b0, cpu_bus_avail = 1'b0;
    logic        halt = 1'b0, read = 1'b0, write = 1'b0, en_upper = 1'b0, en_lower = 1'b0;
    logic [15:0] blt_address = '0;
    logic [7:0]  blt_wdata = '0, mem_rdata = '0;
    logic        cpu_halt, halt_ack, blt_ack, blt_owns_bus, mem_oe, mem_we_upper, mem_we_lower;
    logic [7:0]  blt_rdata, mem_wdata;
    logic [15:0] mem_addr;

    sc1_bus_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .clk(clk), .reset(reset), .e_sync(e_sync), .cpu_bus_avail(cpu_bus_avail),
        .cpu_halt(cpu_halt), .halt(halt), .halt_ack(halt_ack), .read(read), .write(write),
        .blt_address(blt_address), .blt_wdata(blt_wdata), .en_upper(en_upper),
        .en_lower(en_lower), .blt_ack(blt_ack), .blt_rdata(blt_rdata),
        .blt_owns_bus(blt_owns_bus), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_oe(mem_oe), .mem_we_upper(mem_we_upper),
        .mem_we_lower(mem_we_lower)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          ack;
        int          st;
        bit          w, oe, wu, wl;
        logic [15:0] a;
        logic [7:0]  wd, rd;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         ack_cycs[$];
    int         total = 0, bad = 0;
    logic [7:0] last_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int          st_cnt = 0;
    logic        s_oe = 0, s_wu = 0, s_wl = 0;
    logic [15:0] s_a = '0;

    always @(negedge clk) begin
        if (reset) begin
            st_cnt = 0; s_oe = 0; s_wu = 0; s_wl = 0;
        end else begin
            if (mem_oe || mem_we_upper || mem_we_lower) begin
                st_cnt++;
                s_oe |= mem_oe; s_wu |= mem_we_upper; s_wl |= mem_we_lower;
                s_a = mem_addr;
            end
            if (blt_ack) begin
                ack_cycs.push_back(cyc);
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack: got ack at cycle %0d want none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("ack_cycle", cyc, e.ack);
                    check("strobe_cycles", st_cnt, e.st);
                    check("oe_seen", {31'b0, s_oe}, {31'b0, e.oe});
                    check("we_upper_seen", {31'b0, s_wu}, {31'b0, e.wu});
                    check("we_lower_seen", {31'b0, s_wl}, {31'b0, e.wl});
                    check("mem_addr", mem_addr, e.a);
                    if (e.st > 0) check("strobe_addr", s_a, e.a);
                    if (e.w) check("mem_wdata", mem_wdata, e.wd);
                    check("blt_rdata", blt_rdata, e.rd);
                end
                st_cnt = 0; s_oe = 0; s_wu = 0; s_wl = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge while in GRANTED; returns at the next GRANTED negedge.
    task automatic do_access(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] wd,
                             input bit eu, input bit el, input logic [7:0] md, input bit drop);
        exp_t x;
        int n;
        x.w = wr; x.oe = rd && !wr; x.wu = wr && eu; x.wl = wr && el;
        x.st = (x.oe || x.wu || x.wl) ? AC : 0;
        x.a = a; x.wd = wd;
        if (x.oe) last_rd = md;
        x.rd = last_rd;
        x.ack = cyc + AC + 1;
        sb.push_back(x);
        read = rd; write = wr; blt_address = a; blt_wdata = wd;
        en_upper = eu; en_lower = el; mem_rdata = md;
        n = 0;
        do begin
            tick();
            if (drop) halt = 1'b0;
            n++;
        end while (!blt_ack && n < 20);
        if (!blt_ack) begin
            total++; bad++;
            $display("FAIL ack_timeout: got no ack want ack by cycle %0d", x.ack);
        end
        read = 1'b0; write = 1'b0;
        tick();
    endtask

    task automatic grant();
        int n;
        cpu_bus_avail = 1'b1; halt = 1'b1; e_sync = 1'b1;
        tick();
        e_sync = 1'b0;
        n = 0;
        while (!halt_ack && n < 20) begin tick(); n++; end
        check("grant_reached", {31'b0, halt_ack}, 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_cpu_halt", {31'b0, cpu_halt}, 32'd0);
        check("rst_halt_ack", {31'b0, halt_ack}, 32'd0);
        check("rst_owns_bus", {31'b0, blt_owns_bus}, 32'd0);
        check("rst_blt_ack", {31'b0, blt_ack}, 32'd0);
        check("rst_strobes", {29'b0, mem_oe, mem_we_upper, mem_we_lower}, 32'd0);
        check("rst_rdata", blt_rdata, 32'h00);
        check("rst_addr", mem_addr, 32'h0000);
        reset = 1'b0;

        halt = 1'b1; cpu_bus_avail = 1'b1;
        tick();
        check("halt_req_cpu_halt", {31'b0, cpu_halt}, 32'd1);
        check("halt_req_no_ack", {31'b0, halt_ack}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_grant_without_e", {31'b0, halt_ack}, 32'd0);
        end
        e_sync = 1'b1;
        tick();
        e_sync = 1'b0;
        check("grant_after_e", {31'b0, halt_ack}, 32'd1);
        check("grant_owns_bus", {31'b0, blt_owns_bus}, 32'd1);
        check("grant_cpu_halt", {31'b0, cpu_halt}, 32'd1);

        do_access(1, 0, 16'h1234, 8'h00, 0, 0, 8'hA5, 0);
        do_access(0, 1, 16'h2000, 8'h3C, 1, 0, 8'h00, 0);
        do_access(0, 1, 16'h2001, 8'h77, 0, 0, 8'h00, 0);
        do_access(1, 1, 16'h2002, 8'hC3, 1, 1, 8'h99, 0);

        ack_cycs.delete();
        for (int i = 0; i < 4; i++) begin
            do_access(1, 0, 16'h1000 + 16'(i), 8'h00, 0, 0, 8'h10 + 8'(i), 0);
            do_access(0, 1, 16'h3000 + 16'(i), 8'h10 + 8'(i), 1, 1, 8'h00, 0);
        end
        check("b2b_ack_count", ack_cycs.size(), 32'd8);
        for (int i = 0; i + 1 < ack_cycs.size(); i++)
            check("b2b_ack_spacing", ack_cycs[i+1] - ack_cycs[i], AC + 2);

        do_access(1, 0, 16'h4000, 8'h00, 0, 0, 8'h5A, 1);
        check("drop_still_granted", {31'b0, halt_ack}, 32'd1);
        tick();
        check("release_cpu_halt", {31'b0, cpu_halt}, 32'd0);
        check("release_halt_ack", {31'b0, halt_ack}, 32'd0);
        check("release_owns_bus", {31'b0, blt_owns_bus}, 32'd0);
        halt = 1'b1;
        repeat (2) begin
            tick();
            check("release_ignores_halt", {31'b0, cpu_halt}, 32'd0);
        end
        cpu_bus_avail = 1'b0;
        tick();
        check("idle_cpu_halt", {31'b0, cpu_halt}, 32'd0);
        tick();
        check("rehalt_cpu_halt", {31'b0, cpu_halt}, 32'd1);
        check("rehalt_no_ack", {31'b0, halt_ack}, 32'd0);

        grant();
        write = 1'b1; blt_address = 16'h5555; blt_wdata = 8'hFF; en_upper = 1'b1; en_lower = 1'b1;
        tick();
        check("mid_access_strobe", {31'b0, mem_we_upper}, 32'd1);
        reset = 1'b1; write = 1'b0; halt = 1'b0;
        tick();
        check("mid_rst_strobes", {29'b0, mem_oe, mem_we_upper, mem_we_lower}, 32'd0);
        check("mid_rst_cpu_halt", {31'b0, cpu_halt}, 32'd0);
        check("mid_rst_halt_ack", {31'b0, halt_ack}, 32'd0);
        check("mid_rst_blt_ack", {31'b0, blt_ack}, 32'd0);
        check("mid_rst_rdata", blt_rdata, 32'h00);
        reset = 1'b0; last_rd = '0;
        repeat (4) tick();
        check("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
